if_fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS 5-stage pipelined CPU. Owns the PC, runs a request/acknowledge handshake with the instruction ROM, and presents the fetched instruction, its PC and a valid flag to the ID stage, where the controller decodes it. It obeys the controller's if_en/if_rst/pc_src outputs and drives fetch_busy back as the controller's rom_stall.

---
 rtl/if_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 635 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage. Owns the PC, runs the ROM req/ack
// handshake, keeps a one-entry skid buffer and drives the ID registers.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_en,
    input  logic        if_rst,
    input  logic [2:0]  pc_src,
    input  logic [31:0] jump_target,
    input  logic [31:0] branch_target,
    input  logic [31:0] fwd_target,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    output logic        fetch_busy,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        KILL,
        HOLD
    } state_t;

    localparam logic [2:0] SRC_JUMP   = 3'd1;
    localparam logic [2:0] SRC_BRANCH = 3'd2;
    localparam logic [2:0] SRC_FWD    = 3'd3;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] req_addr;
    logic [31:0] req_addr_n;
    logic [31:0] skid_data;
    logic [31:0] skid_data_n;
    logic [31:0] skid_pc;
    logic [31:0] skid_pc_n;
    logic [31:0] inst_n;
    logic [31:0] pc_id_n;
    logic        valid_n;
    logic        xfer;
    logic        pending;
    logic        redirect;
    logic [31:0] target;

    assign rom_req    = (state == WAIT) || (state == KILL);
    assign rom_addr   = req_addr;
    assign xfer       = rom_req && rom_ack;
    assign pending    = rom_req && !rom_ack;
    assign fetch_busy = pending;

    always_comb begin
        target   = pc;
        redirect = 1'b0;
        case (pc_src)
            SRC_JUMP: begin
                target   = jump_target;
                redirect = if_en;
            end
            SRC_BRANCH: begin
                target   = branch_target;
                redirect = if_en;
            end
            SRC_FWD: begin
                target   = fwd_target;
                redirect = if_en;
            end
            default: begin
                target   = pc;
                redirect = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        skid_data_n = skid_data;
        skid_pc_n   = skid_pc;
        inst_n      = inst_id;
        pc_id_n     = pc_id;
        valid_n     = if_valid;
        if (if_rst) begin
            inst_n      = '0;
            valid_n     = 1'b0;
            skid_data_n = '0;
            skid_pc_n   = '0;
            state_n     = pending ? KILL : WAIT;
        end else if (redirect) begin
            inst_n      = '0;
            valid_n     = 1'b0;
            skid_data_n = '0;
            skid_pc_n   = '0;
            pc_n        = {target[31:2], 2'b00};
            state_n     = pending ? KILL : WAIT;
        end else if (!if_en) begin
            unique case (state)
                IDLE: state_n = WAIT;
                WAIT: begin
                    if (xfer) begin
                        skid_data_n = rom_data;
                        skid_pc_n   = req_addr;
                        pc_n        = pc + 32'd4;
                        state_n     = HOLD;
                    end
                end
                KILL: begin
                    if (xfer) state_n = WAIT;
                end
                HOLD: state_n = HOLD;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    inst_n  = '0;
                    valid_n = 1'b0;
                    state_n = WAIT;
                end
                WAIT: begin
                    if (xfer) begin
                        inst_n  = rom_data;
                        pc_id_n = req_addr;
                        valid_n = 1'b1;
                        pc_n    = pc + 32'd4;
                    end else begin
                        inst_n  = '0;
                        valid_n = 1'b0;
                    end
                end
                KILL: begin
                    inst_n  = '0;
                    valid_n = 1'b0;
                    if (xfer) state_n = WAIT;
                end
                HOLD: begin
                    inst_n  = skid_data;
                    pc_id_n = skid_pc;
                    valid_n = 1'b1;
                    state_n = WAIT;
                end
            endcase
        end
    end

    // The address only moves once the ROM has taken the current request.
    assign req_addr_n = pending ? req_addr : pc_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            skid_data <= '0;
            skid_pc   <= '0;
            inst_id   <= '0;
            pc_id     <= '0;
            if_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_addr  <= req_addr_n;
            skid_data <= skid_data_n;
            skid_pc   <= skid_pc_n;
            inst_id   <= inst_n;
            pc_id     <= pc_id_n;
            if_valid  <= valid_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus a randomized run checked
// against an in-order delivery scoreboard and a behavioural ROM.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_en;
    logic        if_rst;
    logic [2:0]  pc_src;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] fwd_target;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic        fetch_busy;
    logic [31:0] inst_id;
    logic [31:0] pc_id;
    logic        if_valid;
    logic        rom_req2;
    logic [31:0] rom_addr2;
    logic [31:0] rom_data2;
    logic        fetch_busy2;
    logic [31:0] inst_id2;
    logic [31:0] pc_id2;
    logic        if_valid2;

    int errors = 0;
    int checks = 0;
    int wcnt   = 0;
    int wlim   = 0;
    int wfix   = 0;
    bit wrand  = 1'b0;
    int wmax   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_data2 = rom_f(rom_addr2);

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .if_en        (if_en),
        .if_rst       (if_rst),
        .pc_src       (pc_src),
        .jump_target  (jump_target),
        .branch_target(branch_target),
        .fwd_target   (fwd_target),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .fetch_busy   (fetch_busy),
        .inst_id      (inst_id),
        .pc_id        (pc_id),
        .if_valid     (if_valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .if_en        (if_en),
        .if_rst       (if_rst),
        .pc_src       (pc_src),
        .jump_target  (jump_target),
        .branch_target(branch_target),
        .fwd_target   (fwd_target),
        .rom_req      (rom_req2),
        .rom_addr     (rom_addr2),
        .rom_ack      (1'b1),
        .rom_data     (rom_data2),
        .fetch_busy   (fetch_busy2),
        .inst_id      (inst_id2),
        .pc_id        (pc_id2),
        .if_valid     (if_valid2)
    );

    function automatic int pick_wait();
        if (wrand) return int'($urandom_range(0, wmax));
        return wfix;
    endfunction

    // ROM model: acks after wlim wait cycles, data is a hash of the address
    task automatic respond();
        rom_ack  = rom_req && (wcnt >= wlim);
        rom_data = rom_f(rom_addr);
        #1;
    endtask

    task automatic edge_step();
        logic hs;
        logic rq;
        hs = rom_req && rom_ack;
        rq = rom_req;
        @(posedge clk);
        #1;
        if (hs) begin
            wcnt = 0;
            wlim = pick_wait();
        end else if (rq) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        if_en         = 1'b1;
        if_rst        = 1'b0;
        pc_src        = 3'd0;
        jump_target   = '0;
        branch_target = '0;
        fwd_target    = '0;
        wcnt          = 0;
        wlim          = pick_wait();
        respond();
        edge_step();
        respond();
        edge_step();
        rst  = 1'b0;
        wcnt = 0;
        wlim = pick_wait();
    endtask

    task automatic test_reset();
        wfix  = 0;
        wrand = 1'b0;
        do_reset();
        respond();
        checks++;
        if (rom_req !== 1'b0) begin
            errors++; $display("FAIL reset_req got=%b exp=0", rom_req);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b exp=0", if_valid);
        end
        checks++;
        if (inst_id !== 32'h0) begin
            errors++; $display("FAIL reset_inst got=%h exp=0", inst_id);
        end
        checks++;
        if (pc_id !== 32'h0) begin
            errors++; $display("FAIL reset_pcid got=%h exp=0", pc_id);
        end
        checks++;
        if (fetch_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b exp=0", fetch_busy);
        end
        edge_step();
        respond();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req req=%b addr=%h exp 1/0",
                     rom_req, rom_addr);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        wfix  = 0;
        wrand = 1'b0;
        do_reset();
        respond();
        edge_step();
        for (int i = 0; i < 4; i++) begin
            respond();
            checks++;
            if (rom_req !== 1'b1 || rom_addr !== 32'(4 * i)
                || fetch_busy !== 1'b0) begin
                errors++;
                $display("FAIL zw_addr i=%0d req=%b addr=%h busy=%b exp 1/%h/0",
                         i, rom_req, rom_addr, fetch_busy, 32'(4 * i));
            end
            if (i == 0) begin
                checks++;
                if (if_valid !== 1'b0) begin
                    errors++; $display("FAIL zw_first_valid got=%b exp=0", if_valid);
                end
            end else begin
                e = 32'(4 * (i - 1));
                checks++;
                if (if_valid !== 1'b1 || pc_id !== e || inst_id !== rom_f(e)) begin
                    errors++;
                    $display("FAIL zw_deliver v=%b pc=%h inst=%h exp 1/%h/%h",
                             if_valid, pc_id, inst_id, e, rom_f(e));
                end
            end
            edge_step();
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] e;
        wfix  = 3;
        wrand = 1'b0;
        do_reset();
        respond();
        edge_step();
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 4; w++) begin
                respond();
                checks++;
                if (rom_addr !== 32'(4 * k) || fetch_busy !== (w < 3)) begin
                    errors++;
                    $display("FAIL ws_addr k=%0d w=%0d addr=%h busy=%b exp %h/%b",
                             k, w, rom_addr, fetch_busy, 32'(4 * k), (w < 3));
                end
                if (w == 0 && k > 0) begin
                    e = 32'(4 * (k - 1));
                    checks++;
                    if (if_valid !== 1'b1 || pc_id !== e || inst_id !== rom_f(e)) begin
                        errors++;
                        $display("FAIL ws_deliver v=%b pc=%h inst=%h exp 1/%h/%h",
                                 if_valid, pc_id, inst_id, e, rom_f(e));
                    end
                end else begin
                    checks++;
                    if (if_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL ws_bubble k=%0d w=%0d got=%b exp=0",
                                 k, w, if_valid);
                    end
                end
                edge_step();
            end
        end
    endtask

    task automatic test_hold();
        wfix  = 0;
        wrand = 1'b0;
        do_reset();
        respond();
        edge_step();
        respond();
        edge_step();
        respond();
        edge_step();
        if_en = 1'b0;
        respond();
        checks++;
        if (rom_addr !== 32'h8 || pc_id !== 32'h4 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_pre addr=%h pc=%h v=%b exp 8/4/1",
                     rom_addr, pc_id, if_valid);
        end
        edge_step();
        respond();
        checks++;
        if (rom_req !== 1'b0 || pc_id !== 32'h4 || if_valid !== 1'b1
            || inst_id !== rom_f(32'h4)) begin
            errors++;
            $display("FAIL hold_stall req=%b pc=%h v=%b inst=%h exp 0/4/1/%h",
                     rom_req, pc_id, if_valid, inst_id, rom_f(32'h4));
        end
        edge_step();
        if_en = 1'b1;
        respond();
        checks++;
        if (rom_req !== 1'b0 || pc_id !== 32'h4) begin
            errors++;
            $display("FAIL hold_release req=%b pc=%h exp 0/4", rom_req, pc_id);
        end
        edge_step();
        respond();
        checks++;
        if (if_valid !== 1'b1 || pc_id !== 32'h8 || inst_id !== rom_f(32'h8)) begin
            errors++;
            $display("FAIL hold_skid v=%b pc=%h inst=%h exp 1/8/%h",
                     if_valid, pc_id, inst_id, rom_f(32'h8));
        end
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'hC) begin
            errors++;
            $display("FAIL hold_next_req req=%b addr=%h exp 1/c", rom_req, rom_addr);
        end
        edge_step();
        respond();
        checks++;
        if (if_valid !== 1'b1 || pc_id !== 32'hC) begin
            errors++;
            $display("FAIL hold_once v=%b pc=%h exp 1/c", if_valid, pc_id);
        end
    endtask

    task automatic test_jump();
        bit fired = 1'b0;
        bit found = 1'b0;
        bit seen  = 1'b0;
        logic [31:0] got = '0;
        wfix  = 2;
        wrand = 1'b0;
        do_reset();
        respond();
        edge_step();
        for (int i = 0; i < 40 && !fired; i++) begin
            respond();
            if (rom_req && rom_addr == 32'h8 && !rom_ack) begin
                pc_src      = 3'd1;
                jump_target = 32'h43;
                fired       = 1'b1;
            end
            edge_step();
            pc_src      = 3'd0;
            jump_target = '0;
        end
        checks++;
        if (!fired) begin
            errors++; $display("FAIL jump_fire got=0 exp=1 (fetch of 8 not seen)");
        end
        respond();
        checks++;
        if (rom_addr !== 32'h8 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_kill addr=%h v=%b exp 8/0", rom_addr, if_valid);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            if (i > 0) respond();
            if (rom_req && rom_addr == 32'h40) seen = 1'b1;
            if (if_valid) begin
                found = 1'b1;
                got   = pc_id;
            end else begin
                edge_step();
            end
        end
        checks++;
        if (!found || got !== 32'h40 || inst_id !== rom_f(32'h40)) begin
            errors++;
            $display("FAIL jump_target found=%b pc=%h inst=%h exp 1/40/%h",
                     found, got, inst_id, rom_f(32'h40));
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL jump_req40 got=0 exp=1");
        end
    endtask

    task automatic test_fwd();
        bit fired = 1'b0;
        wfix  = 0;
        wrand = 1'b0;
        do_reset();
        respond();
        edge_step();
        for (int i = 0; i < 20 && !fired; i++) begin
            respond();
            if (rom_req && rom_ack && rom_addr == 32'h10) begin
                pc_src     = 3'd3;
                fwd_target = 32'h100;
                fired      = 1'b1;
            end
            edge_step();
            pc_src     = 3'd0;
            fwd_target = '0;
        end
        checks++;
        if (!fired) begin
            errors++; $display("FAIL fwd_fire got=0 exp=1 (ack of 10 not seen)");
        end
        respond();
        checks++;
        if (if_valid !== 1'b0 || rom_addr !== 32'h100) begin
            errors++;
            $display("FAIL fwd_bubble v=%b addr=%h exp 0/100", if_valid, rom_addr);
        end
        edge_step();
        respond();
        checks++;
        if (if_valid !== 1'b1 || pc_id !== 32'h100
            || inst_id !== rom_f(32'h100)) begin
            errors++;
            $display("FAIL fwd_deliver v=%b pc=%h inst=%h exp 1/100/%h",
                     if_valid, pc_id, inst_id, rom_f(32'h100));
        end
    endtask

    task automatic test_rst_mid();
        wfix  = 3;
        wrand = 1'b0;
        do_reset();
        respond();
        edge_step();
        for (int i = 0; i < 4; i++) begin
            respond();
            edge_step();
        end
        respond();
        checks++;
        if (if_valid !== 1'b1 || rom_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre v=%b req=%b exp 1/1", if_valid, rom_req);
        end
        rst = 1'b1;
        edge_step();
        respond();
        checks++;
        if (rom_req !== 1'b0 || if_valid !== 1'b0 || inst_id !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_clear req=%b v=%b inst=%h exp 0/0/0",
                     rom_req, if_valid, inst_id);
        end
        rst = 1'b0;
        edge_step();
        respond();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_restart req=%b addr=%h exp 1/0", rom_req, rom_addr);
        end
    endtask

    task automatic test_if_rst();
        wfix  = 0;
        wrand = 1'b0;
        do_reset();
        respond();
        edge_step();
        respond();
        edge_step();
        respond();
        edge_step();
        respond();
        if_rst = 1'b1;
        edge_step();
        if_rst = 1'b0;
        respond();
        checks++;
        if (if_valid !== 1'b0 || inst_id !== 32'h0 || rom_req !== 1'b1
            || rom_addr !== 32'h8) begin
            errors++;
            $display("FAIL ifrst_wait v=%b inst=%h req=%b addr=%h exp 0/0/1/8",
                     if_valid, inst_id, rom_req, rom_addr);
        end
        edge_step();
        respond();
        checks++;
        if (if_valid !== 1'b1 || pc_id !== 32'h8) begin
            errors++;
            $display("FAIL ifrst_refetch v=%b pc=%h exp 1/8", if_valid, pc_id);
        end
        if_en = 1'b0;
        edge_step();
        respond();
        checks++;
        if (rom_req !== 1'b0) begin
            errors++; $display("FAIL ifrst_hold_req got=%b exp=0", rom_req);
        end
        if_rst = 1'b1;
        if_en  = 1'b1;
        edge_step();
        if_rst = 1'b0;
        respond();
        checks++;
        if (if_valid !== 1'b0 || rom_req !== 1'b1 || rom_addr !== 32'h10) begin
            errors++;
            $display("FAIL ifrst_hold v=%b req=%b addr=%h exp 0/1/10",
                     if_valid, rom_req, rom_addr);
        end
        edge_step();
        respond();
        checks++;
        if (if_valid !== 1'b1 || pc_id !== 32'h10) begin
            errors++;
            $display("FAIL ifrst_hold_next v=%b pc=%h exp 1/10", if_valid, pc_id);
        end
    endtask

    task automatic test_wrap();
        wfix  = 0;
        wrand = 1'b0;
        do_reset();
        respond();
        edge_step();
        respond();
        checks++;
        if (rom_req2 !== 1'b1 || rom_addr2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first req=%b addr=%h exp 1/fffffffc",
                     rom_req2, rom_addr2);
        end
        edge_step();
        respond();
        checks++;
        if (rom_addr2 !== 32'h0 || if_valid2 !== 1'b1
            || pc_id2 !== 32'hFFFF_FFFC || inst_id2 !== rom_f(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_next addr=%h v=%b pc=%h inst=%h exp 0/1/fffffffc",
                     rom_addr2, if_valid2, pc_id2, inst_id2);
        end
        edge_step();
        respond();
        checks++;
        if (if_valid2 !== 1'b1 || pc_id2 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero v=%b pc=%h exp 1/0", if_valid2, pc_id2);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] tgt;
        logic [31:0] h_inst;
        logic [31:0] h_pc;
        logic [31:0] addr_prev;
        logic        h_valid;
        logic        redir;
        logic        en;
        logic        pend_prev;
        int          r;
        int          n_del;
        wrand = 1'b1;
        wmax  = 3;
        do_reset();
        respond();
        edge_step();
        exp_next  = 32'h0;
        pend_prev = 1'b0;
        addr_prev = '0;
        n_del     = 0;
        for (int c = 0; c < 3000; c++) begin
            if_en         = ($urandom_range(0, 3) != 0);
            r             = int'($urandom_range(0, 15));
            jump_target   = $urandom;
            branch_target = $urandom;
            fwd_target    = $urandom;
            case (r)
                0: pc_src = 3'd1;
                1: pc_src = 3'd2;
                2: pc_src = 3'd3;
                3: pc_src = 3'(4 + $urandom_range(0, 3));
                default: pc_src = 3'd0;
            endcase
            respond();
            checks++;
            if (fetch_busy !== (rom_req && !rom_ack)) begin
                errors++;
                $display("FAIL rnd_busy c=%0d got=%b exp=%b",
                         c, fetch_busy, rom_req && !rom_ack);
            end
            if (rom_req) begin
                checks++;
                if (rom_addr[1:0] !== 2'b00) begin
                    errors++; $display("FAIL rnd_align c=%0d addr=%h", c, rom_addr);
                end
            end
            if (pend_prev) begin
                checks++;
                if (rom_req !== 1'b1 || rom_addr !== addr_prev) begin
                    errors++;
                    $display("FAIL rnd_stable c=%0d req=%b addr=%h exp 1/%h",
                             c, rom_req, rom_addr, addr_prev);
                end
            end
            en    = if_en;
            redir = if_en && (pc_src == 3'd1 || pc_src == 3'd2 || pc_src == 3'd3);
            tgt   = (pc_src == 3'd1) ? jump_target :
                    (pc_src == 3'd2) ? branch_target : fwd_target;
            h_inst    = inst_id;
            h_pc      = pc_id;
            h_valid   = if_valid;
            pend_prev = rom_req && !rom_ack;
            addr_prev = rom_addr;
            edge_step();
            if (redir) begin
                checks++;
                if (if_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_redir_bubble c=%0d got=%b exp=0",
                                       c, if_valid);
                end
                exp_next = {tgt[31:2], 2'b00};
            end else if (!en) begin
                checks++;
                if (if_valid !== h_valid || pc_id !== h_pc || inst_id !== h_inst) begin
                    errors++;
                    $display("FAIL rnd_hold c=%0d v=%b pc=%h inst=%h exp %b/%h/%h",
                             c, if_valid, pc_id, inst_id, h_valid, h_pc, h_inst);
                end
            end else if (if_valid) begin
                checks++;
                if (pc_id !== exp_next || inst_id !== rom_f(exp_next)) begin
                    errors++;
                    $display("FAIL rnd_order c=%0d pc=%h inst=%h exp %h/%h",
                             c, pc_id, inst_id, exp_next, rom_f(exp_next));
                end
                exp_next = exp_next + 32'd4;
                n_del++;
            end
        end
        checks++;
        if (n_del < 150) begin
            errors++; $display("FAIL rnd_progress got=%0d exp>=150", n_del);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        if_en         = 1'b1;
        if_rst        = 1'b0;
        pc_src        = 3'd0;
        jump_target   = '0;
        branch_target = '0;
        fwd_target    = '0;
        rom_ack       = 1'b0;
        rom_data      = '0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_hold();
        test_jump();
        test_fwd();
        test_rst_mid();
        test_if_rst();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
